// File: rtl/psum_shift_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : psum_shift_accumulator
// Purpose  : Bit-serial partial-sum accumulator placed after the PE array.
//            Each beat's signed PE partial sum is sign-extended, shifted left
//            by its bit-plane weight and added into a wide signed accumulator
//            with saturation. On the last beat of a group, the result and a
//            sticky saturation flag are presented downstream through a
//            valid/ready handshake.
// Ports    : CLK      - clock, rising edge
//            RST      - asynchronous active-high reset
//            i_psum   - signed partial sum from the PE (PSUM_W)
//            i_shift  - left shift for this beat (SHIFT_W)
//            i_last   - final beat of the group
//            i_valid  - upstream beat valid
//            o_ready  - beat can be accepted this cycle
//            o_acc    - signed accumulated result (ACC_W)
//            o_sat    - a clamp occurred somewhere in this group
//            o_valid  - result valid
//            i_ready  - downstream accepts the result
// Revision : 1.0 - initial release
// ============================================================================
module psum_shift_accumulator #(
  parameter int PSUM_W  = 10,
  parameter int SHIFT_W = 3,
  parameter int ACC_W   = 20
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [PSUM_W-1:0]  i_psum,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic               i_last,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [ACC_W-1:0]   o_acc,
  output logic               o_sat,
  output logic               o_valid,
  input  logic               i_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] C_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] C_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               sticky_q, sticky_d;
  logic [ACC_W-1:0]   o_acc_q, o_acc_d;
  logic               o_sat_q, o_sat_d;
  logic               o_valid_q, o_valid_d;

  logic               accept;
  logic               fresh;
  logic [ACC_W-1:0]   acc_base;
  logic               sat_base;
  logic [ACC_W-1:0]   term;
  logic [ACC_W:0]     sum_wide;
  logic               clamp;
  logic [ACC_W-1:0]   sum_sat;

  // Ready depends only on the registered result slot and downstream ready,
  // so there is no combinational path from i_valid/i_last.
  assign o_ready = !o_valid_q || i_ready;
  assign accept  = i_valid && o_ready;

  // Outside ACCUM there is no open group: a new beat starts from zero so
  // nothing from an earlier group can leak in.
  assign fresh    = (state_q != ACCUM);
  assign acc_base = fresh ? '0 : acc_q;
  assign sat_base = fresh ? 1'b0 : sticky_q;

  // ACC_W is wide enough that the shifted term itself never overflows.
  assign term = {{(ACC_W-PSUM_W){i_psum[PSUM_W-1]}}, i_psum} << i_shift;

  // One guard bit; overflow shows up as the top two bits disagreeing.
  assign sum_wide = {acc_base[ACC_W-1], acc_base} + {term[ACC_W-1], term};
  assign clamp    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign sum_sat  = !clamp ? sum_wide[ACC_W-1:0]
                  : (sum_wide[ACC_W] ? C_ACC_MIN : C_ACC_MAX);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sticky_d  = sticky_q;
    o_acc_d   = o_acc_q;
    o_sat_d   = o_sat_q;
    o_valid_d = o_valid_q;

    if (accept) begin
      if (i_last) begin
        o_acc_d   = sum_sat;
        o_sat_d   = sat_base | clamp;
        o_valid_d = 1'b1;
        acc_d     = '0;
        sticky_d  = 1'b0;
        state_d   = DONE;
      end else begin
        // Any held result was popped in this same cycle (accept implies ready).
        acc_d     = sum_sat;
        sticky_d  = sat_base | clamp;
        o_valid_d = 1'b0;
        state_d   = ACCUM;
      end
    end else if (state_q == DONE && i_ready) begin
      o_valid_d = 1'b0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      sticky_q  <= 1'b0;
      o_acc_q   <= '0;
      o_sat_q   <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sticky_q  <= sticky_d;
      o_acc_q   <= o_acc_d;
      o_sat_q   <= o_sat_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_acc   = o_acc_q;
  assign o_sat   = o_sat_q;
  assign o_valid = o_valid_q;

endmodule
`default_nettype wire
